// File: rtl/ifu_pkg.sv
// ============================================================================
//  Module      : ifu_pkg
//  Description : Shared types and constants for the instruction fetch unit.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package ifu_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_ERR  = 3'd4
  } ifu_state_e;

  localparam int unsigned PC_INC           = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage : ifu_pkg

`default_nettype wire

// File: rtl/inst_fetch_unit_pc_gen.sv
// ============================================================================
//  Module      : pc_gen
//  Description : PC register with sequential/redirect next-PC and alignment check.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module pc_gen
  import ifu_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  consume_i,
  input  logic                  pc_sel_i,
  input  logic [ADDR_WIDTH-1:0] alu_out_i,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic [ADDR_WIDTH-1:0] pc_plus4_o,
  output logic                  misalign_o
);

  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] pc_d;
  logic [ADDR_WIDTH-1:0] w_target;

  assign pc_plus4_o = pc_q + ADDR_WIDTH'(PC_INC);
  assign pc_o       = pc_q;

  // Redirect targets follow the JALR rule: bit 0 is dropped, bit 1 must be clear.
  always_comb begin
    w_target   = pc_sel_i ? (alu_out_i & ~ADDR_WIDTH'(1)) : pc_plus4_o;
    misalign_o = consume_i & w_target[1];
    pc_d       = (consume_i && !w_target[1]) ? w_target : pc_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule : pc_gen

`default_nettype wire

// File: rtl/inst_fetch_unit.sv
// ============================================================================
//  Module      : inst_fetch_unit
//  Description : RV32I fetch front end: request/grant fetch FSM and instruction
//                hold register. Optional counters under IFU_PERF_CNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module inst_fetch_unit
  import ifu_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  IMemReq,
  output logic [ADDR_WIDTH-1:0] IMemAddr,
  input  logic                  IMemGnt,
  input  logic                  IMemRValid,
  input  logic [DATA_WIDTH-1:0] IMemRData,
  input  logic                  InstReady,
  input  logic                  PCSel,
  input  logic [ADDR_WIDTH-1:0] ALUOut,
  output logic [DATA_WIDTH-1:0] Inst,
  output logic                  InstValid,
  output logic [ADDR_WIDTH-1:0] PC,
  output logic [ADDR_WIDTH-1:0] PCPlus4,
  output logic                  MisalignErr
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]           FetchCnt,
  output logic [31:0]           StallCnt
`endif
);

  ifu_state_e            state_q;
  logic [DATA_WIDTH-1:0] inst_q;
  logic                  inst_valid_q;
  logic                  imem_req_q;
  logic                  misalign_err_q;
  logic                  w_consume;
  logic                  w_misalign;

  assign w_consume   = (state_q == S_HOLD) && InstReady;
  assign IMemReq     = imem_req_q;
  assign IMemAddr    = PC;
  assign Inst        = inst_q;
  assign InstValid   = inst_valid_q;
  assign MisalignErr = misalign_err_q;

  pc_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RESET_PC   (RESET_PC)
  ) u_pc_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .consume_i  (w_consume),
    .pc_sel_i   (PCSel),
    .alu_out_i  (ALUOut),
    .pc_o       (PC),
    .pc_plus4_o (PCPlus4),
    .misalign_o (w_misalign)
  );

  // Responses are only captured in S_WAIT, so a response racing the grant or
  // arriving after an abandoned fetch never reaches Inst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      inst_q         <= '0;
      inst_valid_q   <= 1'b0;
      imem_req_q     <= 1'b0;
      misalign_err_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_q    <= S_REQ;
          imem_req_q <= 1'b1;
        end
        S_REQ: begin
          if (IMemGnt) begin
            state_q    <= S_WAIT;
            imem_req_q <= 1'b0;
          end
        end
        S_WAIT: begin
          if (IMemRValid) begin
            inst_q       <= IMemRData;
            inst_valid_q <= 1'b1;
            state_q      <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (InstReady) begin
            inst_valid_q <= 1'b0;
            if (w_misalign) begin
              state_q        <= S_ERR;
              misalign_err_q <= 1'b1;
            end else begin
              state_q    <= S_REQ;
              imem_req_q <= 1'b1;
            end
          end
        end
        S_ERR: begin
          imem_req_q     <= 1'b0;
          inst_valid_q   <= 1'b0;
          misalign_err_q <= 1'b1;
        end
        default: begin
          state_q    <= S_IDLE;
          imem_req_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;

  assign FetchCnt = fetch_cnt_q;
  assign StallCnt = stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (state_q == S_WAIT && IMemRValid) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if ((state_q == S_REQ && !IMemGnt) || state_q == S_WAIT) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end
`else
  // Performance counters not built.
`endif

endmodule : inst_fetch_unit

`default_nettype wire
